// File: rtl/ram_io_responder.sv
// rtl/ram_io_responder.sv - byte RAM plus memory-mapped TX/RX FIFO window for the fetcher port
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   en_from_fc                access strobe (no side effect when low)
//   addr_from_fc[31:0]        byte address; bit IoSelBit selects the IO window
//   is_store_from_fc          1 = store data_from_fc, 0 = read
//   data_from_fc[7:0]         store byte
//   data_to_fc[7:0]           read byte, registered (one cycle after the read)
//   io_full_to_fc             TX almost full; fetcher holds IO stores
//   tx_overflow               sticky flag: an IO store was dropped
//   tx_data/tx_valid/tx_ready TX FIFO head toward the host
//   rx_data/rx_valid/rx_ready RX FIFO input from the host

module ram_io_responder #(
    parameter int RamAddrWidth = 17,
    parameter int IoSelBit     = 17,
    parameter int TxDepthLog   = 3,
    parameter int RxDepthLog   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_from_fc,
    input  logic [31:0] addr_from_fc,
    input  logic        is_store_from_fc,
    input  logic [7:0]  data_from_fc,
    output logic [7:0]  data_to_fc,
    output logic        io_full_to_fc,
    output logic        tx_overflow,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int TxDepth = 1 << TxDepthLog;
    localparam int RxDepth = 1 << RxDepthLog;
    localparam logic [TxDepthLog:0] TxFullCount   = (TxDepthLog+1)'(TxDepth);
    localparam logic [TxDepthLog:0] TxAlmostCount = (TxDepthLog+1)'(TxDepth - 1);
    localparam logic [RxDepthLog:0] RxFullCount   = (RxDepthLog+1)'(RxDepth);

    logic [7:0]            r_mem [0:(1<<RamAddrWidth)-1];
    logic [7:0]            r_tx_buf [0:TxDepth-1];
    logic [7:0]            r_rx_buf [0:RxDepth-1];
    logic [TxDepthLog-1:0] r_tx_rd, r_tx_wr;
    logic [TxDepthLog:0]   r_tx_count;
    logic [RxDepthLog-1:0] r_rx_rd, r_rx_wr;
    logic [RxDepthLog:0]   r_rx_count;
    logic [7:0]            r_data_out;
    logic                  r_tx_overflow;

    logic                    w_is_io;
    logic [RamAddrWidth-1:0] w_ram_addr;
    logic [3:0]              w_io_off;
    logic                    w_tx_full, w_rx_full, w_rx_nonempty;
    logic                    w_tx_store, w_tx_pop, w_tx_push;
    logic                    w_rx_pop, w_rx_push;
    logic                    w_rd_load;
    logic [7:0]              w_rd_next;
    logic                    w_unused_addr;

    assign w_is_io       = addr_from_fc[IoSelBit];
    assign w_ram_addr    = addr_from_fc[RamAddrWidth-1:0];
    assign w_io_off      = addr_from_fc[3:0];
    assign w_unused_addr = ^addr_from_fc;

    assign w_tx_full     = (r_tx_count == TxFullCount);
    assign w_rx_full     = (r_rx_count == RxFullCount);
    assign w_rx_nonempty = (r_rx_count != '0);

    // A pop in the same cycle frees a slot, so a store to a full TX is still accepted.
    assign w_tx_store = en_from_fc & w_is_io & is_store_from_fc & (w_io_off == 4'h0);
    assign w_tx_pop   = tx_valid & tx_ready;
    assign w_tx_push  = w_tx_store & (~w_tx_full | w_tx_pop);

    assign w_rx_pop  = en_from_fc & w_is_io & ~is_store_from_fc & (w_io_off == 4'h0) & w_rx_nonempty;
    assign w_rx_push = rx_valid & rx_ready;

    assign tx_valid      = (r_tx_count != '0);
    assign tx_data       = r_tx_buf[r_tx_rd];
    assign rx_ready      = ~w_rx_full;
    assign io_full_to_fc = (r_tx_count >= TxAlmostCount);
    assign tx_overflow   = r_tx_overflow;
    assign data_to_fc    = r_data_out;

    // Read-data mux: RAM reads happen whenever the RAM is addressed and not being
    // written; IO reads only on a real access. Otherwise the output holds.
    always_comb begin
        w_rd_load = 1'b0;
        w_rd_next = 8'h00;
        if (!w_is_io) begin
            if (!(en_from_fc && is_store_from_fc)) begin
                w_rd_load = 1'b1;
                w_rd_next = r_mem[w_ram_addr];
            end
        end else if (en_from_fc && !is_store_from_fc) begin
            w_rd_load = 1'b1;
            case (w_io_off)
                4'h0:    w_rd_next = w_rx_nonempty ? r_rx_buf[r_rx_rd] : 8'h00;
                4'h4:    w_rd_next = {6'b0, w_rx_nonempty, w_tx_full};
                default: w_rd_next = 8'h00;
            endcase
        end
    end

    // Storage arrays are not reset.
    always_ff @(posedge clk) begin
        if (en_from_fc && is_store_from_fc && !w_is_io)
            r_mem[w_ram_addr] <= data_from_fc;
        if (w_tx_push)
            r_tx_buf[r_tx_wr] <= data_from_fc;
        if (w_rx_push)
            r_rx_buf[r_rx_wr] <= rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_rd       <= '0;
            r_tx_wr       <= '0;
            r_tx_count    <= '0;
            r_rx_rd       <= '0;
            r_rx_wr       <= '0;
            r_rx_count    <= '0;
            r_data_out    <= 8'h00;
            r_tx_overflow <= 1'b0;
        end else begin
            if (w_rd_load)
                r_data_out <= w_rd_next;
            if (w_tx_store && w_tx_full && !w_tx_pop)
                r_tx_overflow <= 1'b1;

            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + 1'b1;
                2'b01:   r_tx_count <= r_tx_count - 1'b1;
                default: r_tx_count <= r_tx_count;
            endcase

            if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + 1'b1;
                2'b01:   r_rx_count <= r_rx_count - 1'b1;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// tb/tb_ram_io_responder.sv - self-checking bench for ram_io_responder
module tb_ram_io_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_from_fc = 1'b0;
    logic [31:0] addr_from_fc = 32'h0;
    logic        is_store_from_fc = 1'b0;
    logic [7:0]  data_from_fc = 8'h0;
    logic [7:0]  data_to_fc;
    logic        io_full_to_fc;
    logic        tx_overflow;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: sparse RAM, two byte queues, expected read byte.
    logic [7:0] m_mem [int];
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    logic [7:0] e_d   = 8'h00;
    logic       e_dk  = 1'b1;
    logic       e_ovf = 1'b0;

    localparam logic [31:0] IoData = 32'h0003_0000;
    localparam logic [31:0] IoStat = 32'h0003_0004;

    ram_io_responder dut (
        .clk(clk), .rst(rst),
        .en_from_fc(en_from_fc), .addr_from_fc(addr_from_fc),
        .is_store_from_fc(is_store_from_fc), .data_from_fc(data_from_fc),
        .data_to_fc(data_to_fc), .io_full_to_fc(io_full_to_fc),
        .tx_overflow(tx_overflow), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, advance the model, sample 1ns after the edge.
    task automatic step(input logic en, input logic [31:0] a, input logic st,
                        input logic [7:0] d, input logic txr, input logic rxv,
                        input logic [7:0] rxd);
        logic pop_tx, push_tx, pop_rx, push_rx;
        logic [3:0] off;
        int ra;
        en_from_fc = en; addr_from_fc = a; is_store_from_fc = st;
        data_from_fc = d; tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        pop_tx  = txr && (txq.size() != 0);
        push_rx = rxv && (rxq.size() < 8);
        push_tx = 1'b0;
        pop_rx  = 1'b0;
        off = a[3:0];
        ra  = int'(a[16:0]);
        if (!a[17]) begin
            if (en && st) begin
                m_mem[ra] = d;
                e_dk = 1'b0;
            end else if (m_mem.exists(ra)) begin
                e_d = m_mem[ra]; e_dk = 1'b1;
            end else begin
                e_dk = 1'b0;
            end
        end else if (en && !st) begin
            e_dk = 1'b1;
            if (off == 4'h0) begin
                if (rxq.size() != 0) begin e_d = rxq[0]; pop_rx = 1'b1; end
                else e_d = 8'h00;
            end else if (off == 4'h4) begin
                e_d = {6'b0, rxq.size() != 0, txq.size() == 8};
            end else begin
                e_d = 8'h00;
            end
        end else if (en && st && off == 4'h0) begin
            if (txq.size() < 8 || pop_tx) push_tx = 1'b1;
            else e_ovf = 1'b1;
        end
        if (pop_tx)  void'(txq.pop_front());
        if (push_tx) txq.push_back(d);
        if (pop_rx)  void'(rxq.pop_front());
        if (push_rx) rxq.push_back(rxd);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        txq.delete(); rxq.delete();
        e_d = 8'h00; e_dk = 1'b1; e_ovf = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (data_to_fc !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data_to_fc); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready got %b want 1", rx_ready); end
        n_checks++; if (io_full_to_fc !== 1'b0) begin n_fail++; $display("FAIL reset_io_full got %b want 0", io_full_to_fc); end
        n_checks++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", tx_overflow); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ram_store_read();
        logic [31:0] a;
        logic [7:0]  d;
        step(1, 32'h10, 1, 8'hAB, 0, 0, 0);
        step(1, 32'h10, 0, 8'h00, 0, 0, 0);
        n_checks++; if (data_to_fc !== 8'hAB) begin n_fail++; $display("FAIL ram_read_0x10 got %h want ab", data_to_fc); end
        // Random addresses with random high bits (bit 17 clear), read back through aliases.
        for (int i = 0; i < 16; i++) begin
            a = $urandom & ~32'h0002_0000;
            d = 8'($urandom);
            step(1, a, 1, d, 0, 0, 0);
            step(1, {$urandom_range(0, 16383), 1'b0, a[16:0]}, 0, 8'h00, 0, 0, 0);
            n_checks++; if (data_to_fc !== d) begin n_fail++; $display("FAIL ram_alias addr %h got %h want %h", a, data_to_fc, d); end
        end
    endtask

    task automatic test_stream();
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) step(1, 32'h100 + i, 1, vals[i], 0, 0, 0);
        step(1, 32'h100, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (data_to_fc !== vals[i]) begin n_fail++; $display("FAIL stream[%0d] got %h want %h", i, data_to_fc, vals[i]); end
            if (i < 3) step(1, 32'h101 + i, 0, 8'h00, 0, 0, 0);
        end
    endtask

    task automatic test_tx_fill_drain();
        for (int i = 0; i < 8; i++) begin
            step(1, IoData, 1, 8'h41 + 8'(i), 0, 0, 0);
            n_checks++; if (io_full_to_fc !== (i >= 6)) begin n_fail++; $display("FAIL tx_io_full after %0d got %b want %b", i + 1, io_full_to_fc, i >= 6); end
        end
        step(1, IoData, 1, 8'h49, 0, 0, 0);
        n_checks++; if (tx_overflow !== 1'b1) begin n_fail++; $display("FAIL tx_overflow_set got %b want 1", tx_overflow); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41 + 8'(i)) begin n_fail++; $display("FAIL tx_drain[%0d] got %b/%h want 1/%h", i, tx_valid, tx_data, 8'h41 + 8'(i)); end
            step(0, IoData, 0, 8'h00, 1, 0, 0);
        end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_empty_after_drain got %b want 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_rx();
        logic [7:0] want [3];
        want = '{8'h55, 8'h66, 8'h00};
        step(0, IoData, 0, 0, 0, 1, 8'h55);
        step(0, IoData, 0, 0, 0, 1, 8'h66);
        step(1, IoStat, 0, 0, 0, 0, 8'h00);
        n_checks++; if (data_to_fc !== 8'h02) begin n_fail++; $display("FAIL rx_status got %h want 02", data_to_fc); end
        for (int i = 0; i < 3; i++) begin
            step(1, IoData, 0, 0, 0, 0, 8'h00);
            n_checks++; if (data_to_fc !== want[i]) begin n_fail++; $display("FAIL rx_pop[%0d] got %h want %h", i, data_to_fc, want[i]); end
        end
    endtask

    task automatic test_tx_full_push_pop();
        test_reset();
        for (int i = 0; i < 8; i++) step(1, IoData, 1, 8'($urandom), 0, 0, 0);
        step(1, IoData, 1, 8'h99, 1, 0, 0);
        n_checks++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_overflow got %b want 0", tx_overflow); end
        step(1, IoStat, 0, 0, 0, 0, 0);
        n_checks++; if (data_to_fc !== 8'h01) begin n_fail++; $display("FAIL full_pushpop_status got %h want 01", data_to_fc); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (tx_valid !== 1'b1 || tx_data !== txq[0]) begin n_fail++; $display("FAIL full_pushpop_drain[%0d] got %h want %h", i, tx_data, txq[0]); end
            step(0, IoData, 0, 0, 1, 0, 0);
        end
        n_checks++; if (txq.size() != 0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_empty got %b want 0", tx_valid); end
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        logic [31:0] a;
        int sel;
        test_reset();
        for (int i = 0; i < 8; i++) begin
            pool[i] = 32'h200 + 32'(i * 37);
            step(1, pool[i], 1, 8'($urandom), 0, 0, 0);
        end
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)      a = pool[$urandom_range(0, 7)];
            else if (sel < 7) a = IoData;
            else if (sel < 9) a = IoStat;
            else              a = IoData | 32'($urandom_range(1, 15));
            step($urandom_range(0, 3) != 0, a, $urandom_range(0, 1) == 1, 8'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 8'($urandom));
            if (e_dk) begin
                n_checks++; if (data_to_fc !== e_d) begin n_fail++; $display("FAIL rand[%0d] data got %h want %h", i, data_to_fc, e_d); end
            end
            n_checks++; if (tx_valid !== (txq.size() != 0)) begin n_fail++; $display("FAIL rand[%0d] tx_valid got %b want %b", i, tx_valid, txq.size() != 0); end
            if (txq.size() != 0) begin
                n_checks++; if (tx_data !== txq[0]) begin n_fail++; $display("FAIL rand[%0d] tx_data got %h want %h", i, tx_data, txq[0]); end
            end
            n_checks++; if (rx_ready !== (rxq.size() < 8)) begin n_fail++; $display("FAIL rand[%0d] rx_ready got %b want %b", i, rx_ready, rxq.size() < 8); end
            n_checks++; if (io_full_to_fc !== (txq.size() >= 7)) begin n_fail++; $display("FAIL rand[%0d] io_full got %b want %b", i, io_full_to_fc, txq.size() >= 7); end
            n_checks++; if (tx_overflow !== e_ovf) begin n_fail++; $display("FAIL rand[%0d] overflow got %b want %b", i, tx_overflow, e_ovf); end
        end
    endtask

    task automatic test_reset_mid_transfer();
        step(1, 32'h10, 1, 8'hAB, 0, 0, 0);
        step(1, 32'h10, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, IoData, 1, 8'hC0 + 8'(i), 0, 0, 0);
        n_checks++; if (data_to_fc !== 8'hAB || tx_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset got %h/%b want ab/1", data_to_fc, tx_valid); end
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_tx_valid got %b want 0", tx_valid); end
        n_checks++; if (data_to_fc !== 8'h00) begin n_fail++; $display("FAIL midreset_data got %h want 00", data_to_fc); end
        @(negedge clk);
        rst = 1'b0;
        step(1, 32'h10, 0, 8'h00, 0, 0, 0);
        n_checks++; if (data_to_fc !== 8'hAB) begin n_fail++; $display("FAIL ram_survives_reset got %h want ab", data_to_fc); end
    endtask

    initial begin
        test_reset();
        test_ram_store_read();
        test_stream();
        test_tx_fill_drain();
        test_rx();
        test_tx_full_push_pop();
        test_random();
        test_reset_mid_transfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
